// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM data-memory responder.
// The tohost word (TOHOST_ADDR) only exists when ARM_DMEM_TOHOST_EN is defined.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [31:0] TOHOST_ADDR = 32'h0000_0400;
  localparam int          WORD_BYTES  = 4;
  localparam int          DATA_W      = 32;

  // A word access must start on a 4-byte boundary.
  function automatic logic addr_misaligned(input logic [31:0] adr);
    return (adr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write port, asynchronous read port.
// No reset and no initial contents.
module dmem_array
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Word write on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/arm_dmem_responder.sv
// Data-memory responder with request/ready handshake and WAIT wait states.
// One access in flight: IDLE accepts, WAIT counts down, RESP precedes a
// registered single-cycle MemReady strobe. Misaligned and out-of-range
// accesses give MemErr=1 and never touch the array.
// Optional feature macro: ARM_DMEM_TOHOST_EN (tohost word at TOHOST_ADDR
// driving TestDone/TestValue); without it both outputs are tied to 0.
module arm_dmem_responder
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr,
  output logic        TestDone,
  output logic [31:0] TestValue
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW       = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [CW-1:0]   CNT_INIT = (WAIT > 0) ? CW'(WAIT - 1) : '0;
  localparam logic [32:0]     LIMIT    = 33'(DEPTH * WORD_BYTES);

  dmem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q;
  logic [31:0]   adr_q, wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, ready_q;

  logic          accept_s, commit_s, we_s;
  logic          acc_wr_s, err_s, tohost_s;
  logic [31:0]   acc_adr_s, acc_data_s, arr_rdata_s, tohost_val_s;

  // With WAIT=0 the commit edge is also the accept edge, so the access is
  // taken straight from the inputs; otherwise from the latched copy.
  assign acc_wr_s   = (state_q == arm_mem_pkg::IDLE) ? MemWrite  : wr_q;
  assign acc_adr_s  = (state_q == arm_mem_pkg::IDLE) ? DataAdr   : adr_q;
  assign acc_data_s = (state_q == arm_mem_pkg::IDLE) ? WriteData : wdata_q;

`ifdef ARM_DMEM_TOHOST_EN
  logic        test_done_q;
  logic [31:0] test_value_q;
  assign tohost_s     = (acc_adr_s == TOHOST_ADDR);
  assign tohost_val_s = test_value_q;
`else
  assign tohost_s     = 1'b0;
  assign tohost_val_s = 32'h0000_0000;
`endif

  assign err_s = (addr_misaligned(acc_adr_s) || ({1'b0, acc_adr_s} >= LIMIT)) && !tohost_s;
  assign we_s  = commit_s && reset && acc_wr_s && !err_s && !tohost_s;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (acc_adr_s[AW+1:2]),
    .wdata_i (acc_data_s),
    .raddr_i (acc_adr_s[AW+1:2]),
    .rdata_o (arr_rdata_s)
  );

  // Next-state, wait counter and accept/commit strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      arm_mem_pkg::IDLE: begin
        if (MemReq) begin
          accept_s = 1'b1;
          cnt_d    = CNT_INIT;
          if (WAIT > 0) begin
            state_d = arm_mem_pkg::WAIT;
          end else begin
            state_d  = arm_mem_pkg::RESP;
            commit_s = 1'b1;
          end
        end else begin
          state_d = arm_mem_pkg::IDLE;
        end
      end
      arm_mem_pkg::WAIT: begin
        if (cnt_q == '0) begin
          state_d  = arm_mem_pkg::RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      arm_mem_pkg::RESP: begin
        state_d = arm_mem_pkg::IDLE;
      end
      default: begin
        state_d = arm_mem_pkg::IDLE;
      end
    endcase
  end

  // Response data: zero on error or store, tohost value or array word on load.
  always_comb begin
    rdata_d = 32'h0000_0000;
    if (err_s || acc_wr_s) begin
      rdata_d = 32'h0000_0000;
    end else if (tohost_s) begin
      rdata_d = tohost_val_s;
    end else begin
      rdata_d = arr_rdata_s;
    end
  end

  // State, request latch and registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= arm_mem_pkg::IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      adr_q   <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_q == arm_mem_pkg::RESP);
      if (accept_s) begin
        wr_q    <= MemWrite;
        adr_q   <= DataAdr;
        wdata_q <= WriteData;
      end
      if (commit_s) begin
        rdata_q <= rdata_d;
        err_q   <= err_s;
      end
    end
  end

`ifdef ARM_DMEM_TOHOST_EN
  // tohost value captured at commit; done strobe aligned with MemReady.
  always_ff @(posedge clk) begin
    if (!reset) begin
      test_done_q  <= 1'b0;
      test_value_q <= 32'h0000_0000;
    end else begin
      test_done_q <= (state_q == arm_mem_pkg::RESP) && wr_q && (adr_q == TOHOST_ADDR);
      if (commit_s && acc_wr_s && tohost_s) begin
        test_value_q <= acc_data_s;
      end
    end
  end

  assign TestDone  = test_done_q;
  assign TestValue = test_value_q;
`else
  assign TestDone  = 1'b0;
  assign TestValue = 32'h0000_0000;
`endif

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;

endmodule

// File: tb/tb_arm_dmem_responder.sv
// Self-checking bench for arm_dmem_responder: a WAIT=2 instance for the
// main scenarios and a WAIT=0 instance for back-to-back traffic, both
// compared against a word-array reference model kept here.
module tb_arm_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        req, wr, req0, wr0;
  logic [31:0] adr, wd, adr0, wd0;
  logic [31:0] rd, tv, rd0, tv0;
  logic        rdy, err, td, rdy0, err0, td0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  logic [31:0] tv_model = 32'h0;

  arm_dmem_responder #(.DEPTH(DEPTH), .WAIT(2)) dut (
    .clk(clk), .reset(reset), .MemReq(req), .MemWrite(wr), .DataAdr(adr),
    .WriteData(wd), .ReadData(rd), .MemReady(rdy), .MemErr(err),
    .TestDone(td), .TestValue(tv)
  );

  arm_dmem_responder #(.DEPTH(DEPTH), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .MemReq(req0), .MemWrite(wr0), .DataAdr(adr0),
    .WriteData(wd0), .ReadData(rd0), .MemReady(rdy0), .MemErr(err0),
    .TestDone(td0), .TestValue(tv0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit tohost_hit(input logic [31:0] a);
`ifdef ARM_DMEM_TOHOST_EN
    return (a == 32'h0000_0400);
`else
    return 1'b0;
`endif
  endfunction

  // One access on the WAIT=2 instance, checked against the model.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
    logic        exp_err;
    logic [31:0] exp_rd;
    bit          exp_td;
    bit          chk_rd;
    int          k;
    exp_err = ((a % 4) != 0 || a >= 32'(DEPTH * 4)) && !tohost_hit(a);
    exp_td  = w && tohost_hit(a);
    chk_rd  = 1'b1;
    exp_rd  = 32'h0;
    if (!exp_err && !w) begin
      if (tohost_hit(a)) exp_rd = tv_model;
      else if (known_m[a / 4]) exp_rd = mem_m[a / 4];
      else chk_rd = 1'b0;
    end
    @(negedge clk);
    req = 1'b1; wr = w; adr = a; wd = d;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'($urandom); adr = $urandom; wd = $urandom;
    k = 0;
    do begin
      @(posedge clk); @(negedge clk);
      k++;
    end while (!rdy && k < 10);
    checks++;
    if (k !== 3 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (ready=%b), expected 3", tag, k, rdy);
    end
    if (rdy === 1'b1) begin
      checks++;
      if (err !== exp_err) begin
        errors++;
        $display("FAIL %s err: got %b expected %b (adr %h)", tag, err, exp_err, a);
      end
      if (chk_rd) begin
        checks++;
        if (rd !== exp_rd) begin
          errors++;
          $display("FAIL %s rdata: got %h expected %h (adr %h)", tag, rd, exp_rd, a);
        end
      end
      checks++;
      if (td !== exp_td) begin
        errors++;
        $display("FAIL %s testdone: got %b expected %b", tag, td, exp_td);
      end
      if (!exp_err && w) begin
        if (tohost_hit(a)) tv_model = d;
        else begin mem_m[a / 4] = d; known_m[a / 4] = 1'b1; end
      end
      @(negedge clk);
      checks++;
      if (rdy !== 1'b0 || td !== 1'b0) begin
        errors++;
        $display("FAIL %s pulse width: ready=%b done=%b expected 0 0", tag, rdy, td);
      end
      checks++;
      if (tv !== tv_model) begin
        errors++;
        $display("FAIL %s testvalue: got %h expected %h", tag, tv, tv_model);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy, err, td, rd, tv} !== 67'h0 || {rdy0, err0, td0, rd0, tv0} !== 67'h0) begin
      errors++;
      $display("FAIL reset: dut %b %b %b %h %h dut0 %b %b %b %h %h expected all 0",
               rdy, err, td, rd, tv, rdy0, err0, td0, rd0, tv0);
    end
    reset = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) do_access(1'b1, 32'(i * 4), $urandom, "fill");
    for (int i = 0; i < 8; i++) do_access(1'b0, 32'($urandom_range(0, DEPTH - 1) * 4), 32'h0, "fill_rd");
  endtask

  task automatic test_store_load();
    do_access(1'b1, 32'h64, 32'hDEAD_BEEF, "st64");
    do_access(1'b0, 32'h64, 32'h0, "ld64");
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 32'h66, 32'h1, "st66_mis");
    do_access(1'b0, 32'h64, 32'h0, "ld64_after_mis");
    do_access(1'b0, 32'h63, 32'h0, "ld63_mis");
  endtask

  task automatic test_out_of_range();
    do_access(1'b0, 32'h100, 32'h0, "ld100_oor");
    do_access(1'b1, 32'hFFFF_FFFC, 32'h1234, "st_top_oor");
    do_access(1'b0, 32'hFC, 32'h0, "ld_last_word");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (kind == 1) a = $urandom | 32'h0000_0100;
      else a = 32'($urandom_range(0, DEPTH - 1) * 4);
      do_access(1'($urandom), a, $urandom, "random");
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; adr = 32'h10; wd = 32'hA5;
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tv_model = 32'h0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rdy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || rd !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: ready seen=%b rdata=%h err=%b expected 0 0 0", seen, rd, err);
    end
    do_access(1'b0, 32'h10, 32'h0, "ld10_after_reset");
  endtask

  task automatic test_tohost();
    do_access(1'b1, 32'h400, 32'h7, "st_tohost");
    do_access(1'b0, 32'h400, 32'h0, "ld_tohost");
    do_access(1'b1, 32'h400, $urandom, "st_tohost2");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_l [4];
    logic [31:0] d_l [4];
    int base, k;
    base = $urandom_range(0, DEPTH - 4);
    for (int i = 0; i < 4; i++) begin
      a_l[i] = 32'((base + i) * 4);
      d_l[i] = $urandom;
    end
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b1; adr0 = a_l[0]; wd0 = d_l[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin adr0 = a_l[i + 1]; wd0 = d_l[i + 1]; end
      else req0 = 1'b0;
      @(negedge clk);
      checks++;
      if (rdy0 !== 1'b0) begin
        errors++;
        $display("FAIL b2b gap %0d: ready got %b expected 0", i, rdy0);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (rdy0 !== 1'b1 || err0 !== 1'b0 || rd0 !== 32'h0) begin
        errors++;
        $display("FAIL b2b store %0d: ready=%b err=%b rdata=%h expected 1 0 0", i, rdy0, err0, rd0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0 = 1'b1; wr0 = 1'b0; adr0 = a_l[i];
      @(posedge clk); #1;
      req0 = 1'b0; adr0 = $urandom;
      k = 0;
      do begin
        @(posedge clk); @(negedge clk);
        k++;
      end while (!rdy0 && k < 10);
      checks++;
      if (k !== 1 || rd0 !== d_l[i] || err0 !== 1'b0) begin
        errors++;
        $display("FAIL b2b load %0d: cycles=%0d rdata=%h err=%b expected 1 %h 0", i, k, rd0, err0, d_l[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    req = 1'b0; wr = 1'b0; adr = 32'h0; wd = 32'h0;
    req0 = 1'b0; wr0 = 1'b0; adr0 = 32'h0; wd0 = 32'h0;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    test_reset();
    test_fill();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_random();
    test_reset_mid_wait();
    test_tohost();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_dmem_responder.md
# arm_dmem_responder

Data-memory responder for the ARM core's load/store port, replacing the zero-latency combinational data memory with a request/ready handshake and a configurable wait-state count. It accepts one word access at a time from the processor (initiator) side, commits writes, returns registered read data, and flags misaligned or out-of-range accesses. It sits between the core's `DataAdr`/`WriteData`/`MemWrite` outputs and its `ReadData` input. It is used by the multicycle and stalling cores and by the directed memory testbench.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words in the array.
- `WAIT`, 2: wait cycles between acceptance and response; 0 is legal.

Ports:
- `clk` input 1: sole clock, rising-edge.
- `reset` input 1: one clock; reset is synchronous and active-low.
- `MemReq` input 1: access request.
- `MemWrite` input 1: 1 = store, 0 = load; sampled with `MemReq`.
- `DataAdr` input 32: byte address.
- `WriteData` input 32: store data.
- `ReadData` output 32: load data; valid while `MemReady`=1.
- `MemReady` output 1: single-cycle response strobe.
- `MemErr` output 1: error status of the current response; valid while `MemReady`=1.
- `TestDone` output 1: tohost write strobe (see Configuration).
- `TestValue` output 32: last value written to tohost.

## Operation
- FSM states:
  - IDLE: if `MemReq`=1, latch `MemWrite`, `DataAdr` and `WriteData`. Go to WAIT if `WAIT`>0, else go to RESP.
  - WAIT: decrement the counter. Go to RESP on the edge where the counter reaches its final cycle. The counter loads `WAIT`-1 at acceptance.
  - RESP: assert `MemReady` for exactly one cycle, then return to IDLE. `MemReq` is ignored in RESP.
- Address check, on latched values:
  - Misaligned if `adr[1:0]`≠0.
  - Out of range if `adr` ≥ `DEPTH`*4.
  - Either condition gives err=1.
- Commit happens on the edge entering RESP:
  - Store with err=0: `RAM[adr[31:2]]` <= latched data.
  - Load with err=0: `ReadData` <= `RAM[adr[31:2]]`.
  - err=1: no array write, `ReadData` <= 0, `MemErr` <= 1.
  - A successful store sets `ReadData` <= 0.
- Inputs are latched at acceptance. The initiator may change them after the accepting edge.
- Array contents are not initialised and not cleared by reset.
- Counter width is max(1, $clog2(`WAIT`+1)). Address compare is full 32-bit unsigned.

## Timing
- Reset values: state IDLE, `MemReady`=0, `MemErr`=0, `ReadData`=0, `TestDone`=0, `TestValue`=0.
- Latency: the request is accepted at edge N. `MemReady` is high in the cycle following edge N+`WAIT`+1.
- Throughput: one access per `WAIT`+2 cycles. A request held high through RESP is accepted again at the IDLE cycle that follows.
- `MemReady`, `MemErr` and `ReadData` are registered. Outputs have no combinational path from inputs.
- Reset low in any state, including WAIT and RESP: the next edge forces IDLE and drops `MemReady`. A pending store is discarded and the array is unchanged.
- A store in RESP to address A followed by a load of A is seen by that load, which is accepted in a later cycle.

## Configuration
- `ARM_DMEM_TOHOST_EN` defined:
  - Address `TOHOST_ADDR` (0x0000_0400) is a valid, non-array word.
  - A store there sets `TestValue` <= data and pulses `TestDone`=1 coincident with `MemReady`.
  - A load there returns `TestValue`.
  - err=0 for both.
- Undefined:
  - `TestDone` and `TestValue` are tied to 0.
  - 0x400 is treated like any other address (out of range for `DEPTH` ≤ 256).

## Structure
- Package `arm_mem_pkg` holds:
  - the state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - `TOHOST_ADDR`;
  - the word-size constant (4).
- One sub-module, `dmem_array`: DEPTH×32 storage with a synchronous write port and an asynchronous read port. The FSM, error check and registers live in the top.

## Test plan
- Store then load, `WAIT`=2: store 0x64 ← 0xDEADBEEF, then load 0x64. Each `MemReady` rises 3 cycles after acceptance. The load returns `ReadData`=0xDEADBEEF, `MemErr`=0.
- Misaligned: store 0x66 ← 0x1, then load 0x64. `MemErr`=1 on the store and the word at 0x64 is unchanged. The load response has `MemErr`=0.
- Out of range, `DEPTH`=64: load 0x100 → `MemErr`=1, `ReadData`=0.
- `WAIT`=0 back-to-back: `MemReq` held high with 4 stores → `MemReady` pulses every 2nd cycle, and the 4 words read back correctly.
- Reset mid-WAIT: store 0x10 ← 0xA5, then `reset`=0 in the WAIT cycle → no `MemReady`, and a later load of 0x10 returns its prior value.
- `ARM_DMEM_TOHOST_EN`: store 0x400 ← 7 → `TestDone` pulses once and `TestValue`=7. Without the macro: `MemErr`=1 and `TestDone` stays 0.
